// File: rtl/switch_debounce.sv
// Switch input conditioner: 2-FF synchroniser, per-bit debounce counters, registered
// rise/fall strobes and a sticky change-event register with acknowledge.
module switch_debounce #(
  parameter int unsigned        WIDTH           = 8,
  parameter int unsigned        DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0]   RESET_VAL       = '0
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] evt_flags,
  output logic             evt_pending,
  input  logic             evt_ack
);

  localparam int unsigned      CntW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0]  CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] sw_db_q, sw_db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] evt_q, evt_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];

  // Synchroniser: only the second stage is allowed to feed the debouncer.
  always_comb begin
    sync1_d = sw_in;
    sync2_d = sync1_q;
  end

  // Per-bit debounce: any return to the accepted level restarts the count; a level that
  // survives DEBOUNCE_CYCLES consecutive samples is accepted and strobed.
  always_comb begin
    sw_db_d = sw_db_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != sw_db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          sw_db_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Sticky events: ack clears old flags, but an edge landing in the ack cycle survives.
  always_comb begin
    evt_d = (evt_ack ? '0 : evt_q) | rise_d | fall_d;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      sw_db_q <= RESET_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
      evt_q   <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sw_db_q <= sw_db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Outputs straight from registers; pending is a plain OR with no added latency.
  always_comb begin
    sw_db       = sw_db_q;
    sw_rise     = rise_q;
    sw_fall     = fall_q;
    evt_flags   = evt_q;
    evt_pending = |evt_q;
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce (WIDTH=8, DEBOUNCE_CYCLES=4, RESET_VAL=0).
// Expected output sets are queued as stimulus is applied and compared after each clock.
module tb_switch_debounce;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic [7:0] sw_in;
  logic [7:0] sw_db, sw_rise, sw_fall, evt_flags;
  logic       evt_pending;
  logic       evt_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] db;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] flags;
    logic       pend;
  } exp_t;

  exp_t sb[$];

  switch_debounce #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(4),
    .RESET_VAL      (8'h00)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .sw_in      (sw_in),
    .sw_db      (sw_db),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .evt_flags  (evt_flags),
    .evt_pending(evt_pending),
    .evt_ack    (evt_ack)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic push(input string tag, input logic [7:0] db, input logic [7:0] rise,
                      input logic [7:0] fall, input logic [7:0] flags);
    exp_t e;
    e.tag   = tag;
    e.db    = db;
    e.rise  = rise;
    e.fall  = fall;
    e.flags = flags;
    e.pend  = |flags;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t       e;
    logic [32:0] got, exp;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty got=0 exp=1");
      return;
    end
    e   = sb.pop_front();
    got = {sw_db, sw_rise, sw_fall, evt_flags, evt_pending};
    exp = {e.db, e.rise, e.fall, e.flags, e.pend};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got db=%h rise=%h fall=%h flags=%h pend=%b exp db=%h rise=%h fall=%h flags=%h pend=%b",
             e.tag, sw_db, sw_rise, sw_fall, evt_flags, evt_pending,
             e.db, e.rise, e.fall, e.flags, e.pend);
    end
  endtask

  // One clock: queue the expectation, let a rising edge pass, compare at the falling edge.
  task automatic cyc(input string tag, input logic [7:0] db, input logic [7:0] rise,
                     input logic [7:0] fall, input logic [7:0] flags);
    push(tag, db, rise, fall, flags);
    @(negedge clk_100MHz);
    compare_front();
  endtask

  initial begin
    reset   = 1'b1;
    sw_in   = 8'h00;
    evt_ack = 1'b0;
    @(negedge clk_100MHz);
    cyc("in_reset", 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;

    // 1. idle
    for (int i = 0; i < 50; i++) cyc("idle", 8'h00, 8'h00, 8'h00, 8'h00);

    // 2. bit0 rises, accepted on the 6th edge
    sw_in = 8'h01;
    for (int i = 0; i < 5; i++) cyc("t2_wait", 8'h00, 8'h00, 8'h00, 8'h00);
    cyc("t2_rise", 8'h01, 8'h01, 8'h00, 8'h01);
    cyc("t2_hold", 8'h01, 8'h00, 8'h00, 8'h01);

    // 3. bit1 bounce, 3 cycles high
    sw_in = 8'h03;
    for (int i = 0; i < 3; i++) cyc("t3_bounce", 8'h01, 8'h00, 8'h00, 8'h01);
    sw_in = 8'h01;
    for (int i = 0; i < 6; i++) cyc("t3_settle", 8'h01, 8'h00, 8'h00, 8'h01);

    // 4. ack clears, then bit0 falls
    evt_ack = 1'b1;
    cyc("t4_ack", 8'h01, 8'h00, 8'h00, 8'h00);
    evt_ack = 1'b0;
    cyc("t4_clear", 8'h01, 8'h00, 8'h00, 8'h00);
    sw_in = 8'h00;
    for (int i = 0; i < 5; i++) cyc("t4_wait", 8'h01, 8'h00, 8'h00, 8'h00);
    cyc("t4_fall", 8'h00, 8'h00, 8'h01, 8'h01);
    cyc("t4_hold", 8'h00, 8'h00, 8'h00, 8'h01);

    // 5. ack coincides with bit7 rise: new event wins, old flag cleared
    sw_in = 8'h80;
    for (int i = 0; i < 5; i++) cyc("t5_wait", 8'h00, 8'h00, 8'h00, 8'h01);
    evt_ack = 1'b1;
    cyc("t5_ack_rise", 8'h80, 8'h80, 8'h00, 8'h80);
    evt_ack = 1'b0;
    cyc("t5_hold", 8'h80, 8'h00, 8'h00, 8'h80);

    // 6. reset at debounce count 2
    sw_in = 8'hFF;
    for (int i = 0; i < 4; i++) cyc("t6_count", 8'h80, 8'h00, 8'h00, 8'h80);
    reset = 1'b1;
    push("t6_reset_now", 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    compare_front();
    @(negedge clk_100MHz);
    cyc("t6_reset_a", 8'h00, 8'h00, 8'h00, 8'h00);
    cyc("t6_reset_b", 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc("t6_wait", 8'h00, 8'h00, 8'h00, 8'h00);
    cyc("t6_rise", 8'hFF, 8'hFF, 8'h00, 8'hFF);
    cyc("t6_hold", 8'hFF, 8'h00, 8'h00, 8'hFF);

    // ack with flags, then ack with nothing pending
    evt_ack = 1'b1;
    cyc("ack_all", 8'hFF, 8'h00, 8'h00, 8'h00);
    cyc("ack_empty", 8'hFF, 8'h00, 8'h00, 8'h00);
    evt_ack = 1'b0;
    cyc("final", 8'hFF, 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
